// File: rtl/svpwm_pkg.sv
// rtl/svpwm_pkg.sv - shared state encodings, defaults and gate decode for svpwm_deadtime
package svpwm_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_LOW   = 3'd0;
    localparam logic [2:0] S_DT_UP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_DT_DN = 3'd3;
    localparam logic [2:0] S_TRIP  = 3'd4;

    // {hi, lo}; only the two on-states ever drive a switch
    function automatic logic [1:0] gate_decode(input state_t st);
        case (st)
            S_LOW:   gate_decode = 2'b01;
            S_HIGH:  gate_decode = 2'b10;
            default: gate_decode = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dt_phase.sv
// rtl/dt_phase.sv - one phase leg dead-time FSM; optional input filter under SVPWM_DT_GLITCH_FILTER_EN
module dt_phase
    import svpwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm,
    input  logic [DT_WIDTH-1:0] dead_cnt,
    input  logic                trip,
    input  logic                trip_clr,
    output logic                gate_h,
    output logic                gate_l
);

    state_t              state, state_nx;
    logic [DT_WIDTH-1:0] dcnt, dcnt_nx;
    logic                pwm_s;

`ifdef SVPWM_DT_GLITCH_FILTER_EN
    logic pwm_q;
    logic pwm_f;

    // A new level is taken once it has been seen on two consecutive edges
    assign pwm_s = (pwm == pwm_q) ? pwm : pwm_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
            pwm_f <= 1'b0;
        end else begin
            pwm_q <= pwm;
            pwm_f <= pwm_s;
        end
    end
`else
    assign pwm_s = pwm;
`endif

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        if (trip) begin
            state_nx = S_TRIP;
        end else begin
            case (state)
                S_LOW: if (pwm_s) begin
                    state_nx = S_DT_UP;
                    dcnt_nx  = dead_cnt;
                end
                S_DT_UP: begin
                    if (!pwm_s)                         state_nx = S_LOW;
                    else if (dcnt <= DT_WIDTH'(1))      state_nx = S_HIGH;
                    else                                dcnt_nx  = dcnt - DT_WIDTH'(1);
                end
                S_HIGH: if (!pwm_s) begin
                    state_nx = S_DT_DN;
                    dcnt_nx  = dead_cnt;
                end
                S_DT_DN: begin
                    if (pwm_s)                          state_nx = S_HIGH;
                    else if (dcnt <= DT_WIDTH'(1))      state_nx = S_LOW;
                    else                                dcnt_nx  = dcnt - DT_WIDTH'(1);
                end
                S_TRIP: if (trip_clr) begin
                    state_nx = S_DT_DN;
                    dcnt_nx  = dead_cnt;
                end
                default: state_nx = S_DT_DN;
            endcase
        end
    end

    // Gates are decoded from the next state so they change on the same edge as the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_DT_DN;
            dcnt   <= '0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else begin
            state            <= state_nx;
            dcnt             <= dcnt_nx;
            {gate_h, gate_l} <= gate_decode(state_nx);
        end
    end

endmodule

// File: rtl/svpwm_deadtime.sv
// rtl/svpwm_deadtime.sv - three-phase dead-time inserter with fault latch; SVPWM_DT_GLITCH_FILTER_EN adds input filtering
module svpwm_deadtime
    import svpwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_a,
    input  logic                pwm_b,
    input  logic                pwm_c,
    input  logic [DT_WIDTH-1:0] dead_cnt,
    input  logic                trip,
    input  logic                trip_clr,
    output logic                gate_ah,
    output logic                gate_al,
    output logic                gate_bh,
    output logic                gate_bl,
    output logic                gate_ch,
    output logic                gate_cl,
    output logic                tripped
);

    dt_phase #(.DT_WIDTH(DT_WIDTH)) u_phase_a (
        .clk(clk), .rst_n(rst_n), .pwm(pwm_a), .dead_cnt(dead_cnt),
        .trip(trip), .trip_clr(trip_clr), .gate_h(gate_ah), .gate_l(gate_al)
    );

    dt_phase #(.DT_WIDTH(DT_WIDTH)) u_phase_b (
        .clk(clk), .rst_n(rst_n), .pwm(pwm_b), .dead_cnt(dead_cnt),
        .trip(trip), .trip_clr(trip_clr), .gate_h(gate_bh), .gate_l(gate_bl)
    );

    dt_phase #(.DT_WIDTH(DT_WIDTH)) u_phase_c (
        .clk(clk), .rst_n(rst_n), .pwm(pwm_c), .dead_cnt(dead_cnt),
        .trip(trip), .trip_clr(trip_clr), .gate_h(gate_ch), .gate_l(gate_cl)
    );

    // Trip wins over clear; a clear outside the fault state finds the latch already low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tripped <= 1'b0;
        else if (trip)     tripped <= 1'b1;
        else if (trip_clr) tripped <= 1'b0;
    end

endmodule

// File: tb/tb_svpwm_deadtime.sv
// tb/tb_svpwm_deadtime.sv - scoreboard bench for svpwm_deadtime
module tb_svpwm_deadtime;

    localparam logic [1:0] L = 2'b01;
    localparam logic [1:0] H = 2'b10;
    localparam logic [1:0] D = 2'b00;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm_a, pwm_b, pwm_c;
    logic [7:0] dead_cnt;
    logic       trip, trip_clr;
    logic       gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, tripped;

    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    svpwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c),
        .dead_cnt(dead_cnt), .trip(trip), .trip_clr(trip_clr),
        .gate_ah(gate_ah), .gate_al(gate_al),
        .gate_bh(gate_bh), .gate_bl(gate_bl),
        .gate_ch(gate_ch), .gate_cl(gate_cl),
        .tripped(tripped)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pk(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic t);
        return {a, b, c, t};
    endfunction

    task automatic check_now();
        sb_t        e;
        logic [6:0] obs;
        e   = sb.pop_front();
        obs = {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, tripped};
        n_assert++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [6:0] exp);
        sb.push_back('{tag, exp});
        check_now();
    endtask

    task automatic tick(input string tag, input logic [6:0] exp);
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1;
        check_now();
    endtask

    always @(negedge clk) begin
        n_assert++;
        assert (!((gate_ah && gate_al) || (gate_bh && gate_bl) || (gate_ch && gate_cl))) else begin
            n_fail++;
            $error("FAIL overlap observed a=%b%b b=%b%b c=%b%b expected no hi&lo",
                   gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl);
        end
    end

    initial begin
        logic [1:0] ea;
        rst_n = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0; pwm_c = 1'b0;
        dead_cnt = 8'd10; trip = 1'b0; trip_clr = 1'b0;

        #3;
        expect_now("reset_state", pk(D, D, D, 1'b0));
        tick("reset_hold", pk(D, D, D, 1'b0));
        rst_n = 1'b1;
        tick("reset_exit_low", pk(L, L, L, 1'b0));
        tick("idle_low", pk(L, L, L, 1'b0));

        pwm_a = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            ea = (k <= 10) ? D : H;
            tick("a_rise_dt10", pk(ea, L, L, 1'b0));
        end
        pwm_a = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            ea = (k <= 10) ? D : L;
            tick("a_fall_dt10", pk(ea, L, L, 1'b0));
        end

        pwm_b = 1'b1;
        for (int k = 1; k <= 4; k++) tick("b_short_pulse", pk(L, D, L, 1'b0));
        pwm_b = 1'b0;
        for (int k = 1; k <= 3; k++) tick("b_suppressed", pk(L, L, L, 1'b0));

        dead_cnt = 8'd0;
        pwm_c = 1'b1;
        tick("c_dt0_rise_gap", pk(L, L, D, 1'b0));
        tick("c_dt0_high", pk(L, L, H, 1'b0));
        tick("c_dt0_high_hold", pk(L, L, H, 1'b0));
        pwm_c = 1'b0;
        tick("c_dt0_fall_gap", pk(L, L, D, 1'b0));
        tick("c_dt0_low", pk(L, L, L, 1'b0));
        for (int r = 0; r < 2; r++) begin
            pwm_c = 1'b1;
            tick("c_toggle_up", pk(L, L, D, 1'b0));
            pwm_c = 1'b0;
            tick("c_toggle_dn", pk(L, L, L, 1'b0));
        end

        dead_cnt = 8'd5;
        pwm_a = 1'b1;
        tick("a_dt5_entry", pk(D, L, L, 1'b0));
        dead_cnt = 8'd2;
        for (int k = 2; k <= 6; k++) begin
            ea = (k <= 5) ? D : H;
            tick("a_dt_latched", pk(ea, L, L, 1'b0));
        end
        pwm_a = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            ea = (k <= 2) ? D : L;
            tick("a_dt2_fall", pk(ea, L, L, 1'b0));
        end

        dead_cnt = 8'd1;
        pwm_b = 1'b1;
        tick("b_dt1_gap", pk(L, D, L, 1'b0));
        tick("b_dt1_high", pk(L, H, L, 1'b0));
        pwm_b = 1'b0;
        tick("b_dt1_fall_gap", pk(L, D, L, 1'b0));
        tick("b_dt1_low", pk(L, L, L, 1'b0));

        dead_cnt = 8'd10;
        pwm_a = 1'b1;
        for (int k = 1; k <= 3; k++) tick("a_pre_trip", pk(D, L, L, 1'b0));
        trip = 1'b1;
        tick("trip_all_off", pk(D, D, D, 1'b1));
        trip = 1'b0;
        tick("trip_hold", pk(D, D, D, 1'b1));
        trip = 1'b1; trip_clr = 1'b1;
        tick("trip_priority", pk(D, D, D, 1'b1));
        trip = 1'b0; pwm_a = 1'b0;
        tick("trip_clear", pk(D, D, D, 1'b0));
        trip_clr = 1'b0;
        for (int k = 2; k <= 11; k++) begin
            ea = (k <= 10) ? D : L;
            tick("post_clear_dead", pk(ea, ea, ea, 1'b0));
        end
        trip_clr = 1'b1;
        tick("clr_ignored", pk(L, L, L, 1'b0));
        trip_clr = 1'b0;

        dead_cnt = 8'd0;
        pwm_a = 1'b1;
        tick("a_dt0_gap", pk(D, L, L, 1'b0));
        tick("a_dt0_high", pk(H, L, L, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_reset", pk(D, D, D, 1'b0));
        tick("async_reset_hold", pk(D, D, D, 1'b0));
        rst_n = 1'b1;
        tick("reset_exit_high", pk(H, L, L, 1'b0));
        pwm_a = 1'b0;
        tick("a_after_reset_gap", pk(D, L, L, 1'b0));
        tick("a_after_reset_low", pk(L, L, L, 1'b0));

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            pwm_a    = 1'($urandom_range(0, 1));
            pwm_b    = 1'($urandom_range(0, 1));
            pwm_c    = 1'($urandom_range(0, 1));
            dead_cnt = 8'($urandom_range(0, 3));
            trip     = ($urandom_range(0, 49) == 0);
            trip_clr = ($urandom_range(0, 9) == 0);
        end
        trip = 1'b0;
        trip_clr = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
